// File: rtl/nco_phase_pi.sv
// NCO phase generator with a PI loop filter: feedback is registered, filtered into a
// saturated frequency word, and integrated into a wrapping DDS phase. Includes a lock detector.
module nco_phase_pi #(
    parameter int               WIDTH       = 16,
    parameter int               INT_WIDTH   = 20,
    parameter logic [WIDTH-1:0] FREE_FREQ   = 16'h4000,
    parameter logic [WIDTH-1:0] LOCK_THRESH = 16'h0100,
    parameter int               LOCK_COUNT  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             loop_open,
    input  logic [3:0]       KP_SHIFT,
    input  logic [3:0]       KI_SHIFT,
    input  logic [WIDTH-1:0] feedback_tdata,
    input  logic             feedback_tvalid,
    output logic [WIDTH-1:0] freq_tdata,
    output logic [WIDTH-1:0] phase_tdata,
    output logic             phase_tvalid,
    output logic             int_sat,
    output logic             locked
);

    localparam logic [7:0] LOCK_CNT_MAX = 8'(LOCK_COUNT);

    function automatic logic signed [INT_WIDTH-1:0] sat_int(input logic signed [INT_WIDTH:0] x);
        if (x[INT_WIDTH] != x[INT_WIDTH-1])
            return x[INT_WIDTH] ? {1'b1, {(INT_WIDTH-1){1'b0}}} : {1'b0, {(INT_WIDTH-1){1'b1}}};
        return x[INT_WIDTH-1:0];
    endfunction

    function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [INT_WIDTH+1:0] x);
        logic [INT_WIDTH-WIDTH+2:0] top;
        top = x[INT_WIDTH+1:WIDTH-1];
        if (!((&top) || !(|top)))
            return x[INT_WIDTH+1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return x[WIDTH-1:0];
    endfunction

    logic signed [WIDTH-1:0]     fb_p1;
    logic                        vld_p1;
    logic signed [INT_WIDTH-1:0] integ;
    logic signed [WIDTH-1:0]     freq_p2;
    logic [WIDTH-1:0]            phase_p2;
    logic [7:0]                  lock_cnt;

    logic signed [WIDTH-1:0]     p_term, i_term, p_eff;
    logic signed [INT_WIDTH:0]   integ_x, i_x, integ_sum;
    logic signed [INT_WIDTH-1:0] integ_upd;
    logic                        integ_clip;
    logic signed [INT_WIDTH+1:0] ff_x, p_x, iu_x, freq_sum;
    logic [WIDTH-1:0]            fb_mag;
    logic                        fb_is_min, in_lock;
    logic [7:0]                  cnt_next;

    // Stage 2 combinational: PI terms, saturating integrator, frequency sum, lock count
    always_comb begin
        p_term     = fb_p1 >>> KP_SHIFT;
        i_term     = fb_p1 >>> KI_SHIFT;
        p_eff      = vld_p1 ? p_term : '0;
        integ_x    = {integ[INT_WIDTH-1], integ};
        i_x        = {{(INT_WIDTH+1-WIDTH){i_term[WIDTH-1]}}, i_term};
        integ_sum  = integ_x + i_x;
        integ_clip = integ_sum[INT_WIDTH] != integ_sum[INT_WIDTH-1];
        integ_upd  = vld_p1 ? sat_int(integ_sum) : integ;
        ff_x       = {{(INT_WIDTH+2-WIDTH){FREE_FREQ[WIDTH-1]}}, FREE_FREQ};
        p_x        = {{(INT_WIDTH+2-WIDTH){p_eff[WIDTH-1]}}, p_eff};
        iu_x       = {{2{integ_upd[INT_WIDTH-1]}}, integ_upd};
        freq_sum   = ff_x + p_x + iu_x;
        // The most negative sample has no positive magnitude; treat it as out of lock.
        fb_is_min  = fb_p1[WIDTH-1] && !(|fb_p1[WIDTH-2:0]);
        fb_mag     = fb_p1[WIDTH-1] ? $unsigned(-fb_p1) : $unsigned(fb_p1);
        in_lock    = !fb_is_min && (fb_mag <= LOCK_THRESH);
        cnt_next   = '0;
        if (in_lock)
            cnt_next = (lock_cnt == LOCK_CNT_MAX) ? lock_cnt : lock_cnt + 8'd1;
    end

    // Stage 1 data register
    always_ff @(posedge clk) begin
        if (enable)
            fb_p1 <= feedback_tdata;
    end

    // Stage 1 valid, stage 2 loop filter and lock detector, phase accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1       <= 1'b0;
            integ        <= '0;
            int_sat      <= 1'b0;
            freq_p2      <= FREE_FREQ;
            phase_p2     <= '0;
            phase_tvalid <= 1'b0;
            lock_cnt     <= '0;
            locked       <= 1'b0;
        end else if (enable) begin
            vld_p1       <= feedback_tvalid;
            phase_p2     <= phase_p2 + $unsigned(freq_p2);
            phase_tvalid <= 1'b1;
            if (loop_open) begin
                integ    <= '0;
                int_sat  <= 1'b0;
                freq_p2  <= FREE_FREQ;
                lock_cnt <= '0;
                locked   <= 1'b0;
            end else begin
                freq_p2 <= sat_w(freq_sum);
                if (vld_p1) begin
                    integ    <= integ_upd;
                    int_sat  <= integ_clip;
                    lock_cnt <= cnt_next;
                    locked   <= (cnt_next == LOCK_CNT_MAX);
                end
            end
        end
    end

    assign freq_tdata  = freq_p2;
    assign phase_tdata = phase_p2;

endmodule
